// File: rtl/afifo_rd_port_if.sv
// Read-side bundle between the async FIFO pop port, the adapter and the
// downstream stream consumer.
//
// Handshake: a word moves on m_data in every cycle where m_valid and m_ready
// are both 1 at the rising clk edge. Once m_valid is raised, m_valid and
// m_data hold until that transfer happens (flush excepted). m_ready may
// change freely and never feeds back combinationally into rinc.
interface afifo_rd_port_if #(
  parameter int DSIZE = 32
);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             flush;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  // Adapter view: pops the FIFO and sources the stream.
  modport master (
    input  rempty, rdata, flush, m_ready,
    output rinc, m_valid, m_data
  );

  // Environment view: the FIFO plus the downstream consumer.
  modport slave (
    output rempty, rdata, flush, m_ready,
    input  rinc, m_valid, m_data
  );
endinterface

// File: rtl/afifo_rd_port.sv
// Read-domain adapter: drains the async FIFO pop port into a registered
// valid/ready stream through a 2-entry skid buffer. rinc depends only on
// rempty, flush and registered occupancy, so m_ready has no combinational
// path to the FIFO.
module afifo_rd_port #(
  parameter int DSIZE = 32,
  parameter int CSIZE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  afifo_rd_port_if.master  bus,
  output logic [CSIZE-1:0] pop_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] slot0_q, slot0_d;
  logic [DSIZE-1:0] slot1_q, slot1_d;
  logic [CSIZE-1:0] pop_cnt_q, pop_cnt_d;
  logic             push;
  logic             pop;

  // Occupancy, skid slots and pop counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      slot0_q   <= '0;
      slot1_q   <= '0;
      pop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

  // Next occupancy and slot contents from push/pop events; flush empties the
  // buffer and leaves the stale data in place.
  always_comb begin
    state_d   = state_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    pop_cnt_d = pop_cnt_q + CSIZE'(push);
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          slot0_d = bus.rdata;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          slot1_d = bus.rdata;
          state_d = ST_TWO;
        end else if (push && pop) begin
          slot0_d = bus.rdata;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          slot0_d = slot1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (bus.flush) begin
      state_d = ST_EMPTY;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
    end
  end

  // Pop strobe, stream outputs and debug state, all from registered state.
  always_comb begin
    push        = rst_n & ~bus.rempty & ~bus.flush & (state_q != ST_TWO);
    pop         = (state_q != ST_EMPTY) & bus.m_ready;
    bus.rinc    = push;
    bus.m_valid = (state_q != ST_EMPTY);
    bus.m_data  = slot0_q;
    pop_cnt     = pop_cnt_q;
    state_o     = state_q;
  end

endmodule

// File: tb/tb_afifo_rd_port.sv
// Directed and random checks of the read-port adapter against a FIFO model
// and an expected-word queue.
module tb_afifo_rd_port;

  logic        clk;
  logic        rst_n;
  logic [15:0] pop_cnt;
  logic [1:0]  state;
  logic [3:0]  pop_cnt4;
  logic [1:0]  state4;

  afifo_rd_port_if #(.DSIZE(32)) bif ();
  afifo_rd_port_if #(.DSIZE(32)) bif4 ();

  afifo_rd_port #(.DSIZE(32), .CSIZE(16)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bif),
    .pop_cnt (pop_cnt),
    .state_o (state)
  );

  afifo_rd_port #(.DSIZE(32), .CSIZE(4)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bif4),
    .pop_cnt (pop_cnt4),
    .state_o (state4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          cmp_cnt;
  int          err_cnt;
  int          total_pushes;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] delivered[$];
  logic        s_rinc;
  logic        s_mv;
  logic [31:0] s_md;
  logic        last_stall;
  logic [31:0] last_md;

  // Drive one cycle from the FIFO model, sample before the edge, score, advance.
  task automatic drive_cycle(input logic rdy, input logic fl, input logic hide);
    bif.rempty  = hide || (fifo_q.size() == 0);
    bif.rdata   = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    bif.m_ready = rdy;
    bif.flush   = fl;
    #1;
    s_rinc = bif.rinc;
    s_mv   = bif.m_valid;
    s_md   = bif.m_data;
    cmp_cnt++;
    if (s_mv !== (exp_q.size() != 0)) begin
      err_cnt++;
      $display("FAIL sb_valid: m_valid=%b required %b", s_mv, exp_q.size() != 0);
    end
    cmp_cnt++;
    if ((s_rinc & bif.rempty) !== 1'b0) begin
      err_cnt++;
      $display("FAIL rinc_while_empty: rinc=%b rempty=%b required rinc=0", s_rinc, bif.rempty);
    end
    if (last_stall) begin
      cmp_cnt++;
      if (s_mv !== 1'b1 || s_md !== last_md) begin
        err_cnt++;
        $display("FAIL stall_hold: m_valid=%b m_data=%h required 1 %h", s_mv, s_md, last_md);
      end
    end
    if (s_mv === 1'b1 && rdy) begin
      delivered.push_back(s_md);
      if (exp_q.size() != 0) begin
        cmp_cnt++;
        if (s_md !== exp_q[0]) begin
          err_cnt++;
          $display("FAIL sb_data: m_data=%h required %h", s_md, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    if (s_rinc === 1'b1 && fifo_q.size() != 0) begin
      exp_q.push_back(fifo_q[0]);
      void'(fifo_q.pop_front());
      total_pushes++;
    end
    if (fl) exp_q.delete();
    last_stall = (s_mv === 1'b1) && !rdy && !fl;
    last_md    = s_md;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    fifo_q      = '{32'hA1, 32'hA2, 32'hA3};
    rst_n       = 1'b0;
    bif.rempty  = 1'b0;
    bif.rdata   = 32'hA1;
    bif.m_ready = 1'b1;
    bif.flush   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cmp_cnt++;
      if (bif.rinc !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_rinc: rinc=%b required 0", bif.rinc);
      end
      cmp_cnt++;
      if (bif.m_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_valid: m_valid=%b required 0", bif.m_valid);
      end
      cmp_cnt++;
      if (bif.m_data !== 32'h0) begin
        err_cnt++;
        $display("FAIL reset_data: m_data=%h required 0", bif.m_data);
      end
      cmp_cnt++;
      if (pop_cnt !== 16'h0 || pop_cnt4 !== 4'h0) begin
        err_cnt++;
        $display("FAIL reset_cnt: pop_cnt=%h pop_cnt4=%h required 0", pop_cnt, pop_cnt4);
      end
      cmp_cnt++;
      if (state !== 2'd0) begin
        err_cnt++;
        $display("FAIL reset_state: state=%0d required 0", state);
      end
      @(posedge clk);
      @(negedge clk);
    end
    fifo_q.delete();
    exp_q.delete();
    last_stall = 1'b0;
    rst_n      = 1'b1;
  endtask

  task automatic test_streaming();
    for (int w = 1; w <= 8; w++) fifo_q.push_back(32'(w));
    for (int i = 0; i <= 8; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        cmp_cnt++;
        if (s_rinc !== 1'b1 || s_mv !== 1'b0) begin
          err_cnt++;
          $display("FAIL stream_first: rinc=%b m_valid=%b required 1 0", s_rinc, s_mv);
        end
      end else begin
        cmp_cnt++;
        if (s_mv !== 1'b1 || s_md !== 32'(i)) begin
          err_cnt++;
          $display("FAIL stream_word: cycle %0d m_valid=%b m_data=%h required 1 %h", i, s_mv, s_md, 32'(i));
        end
      end
    end
    cmp_cnt++;
    if (pop_cnt !== 16'd8 || bif.m_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL stream_end: pop_cnt=%0d m_valid=%b required 8 0", pop_cnt, bif.m_valid);
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    pulses = 0;
    delivered.delete();
    for (int w = 0; w < 5; w++) fifo_q.push_back(32'h11 + 32'(w));
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      if (s_rinc === 1'b1) pulses++;
      if (i >= 1) begin
        cmp_cnt++;
        if (s_mv !== 1'b1 || s_md !== 32'h11) begin
          err_cnt++;
          $display("FAIL bp_hold: cycle %0d m_valid=%b m_data=%h required 1 11", i, s_mv, s_md);
        end
      end
      if (i >= 2) begin
        cmp_cnt++;
        if (s_rinc !== 1'b0) begin
          err_cnt++;
          $display("FAIL bp_rinc_off: cycle %0d rinc=%b required 0", i, s_rinc);
        end
      end
    end
    cmp_cnt++;
    if (pulses != 2) begin
      err_cnt++;
      $display("FAIL bp_pulses: rinc pulses=%0d required 2", pulses);
    end
    for (int i = 6; i < 12; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      if (i == 6 || i == 7) begin
        cmp_cnt++;
        if (s_rinc !== (i == 7)) begin
          err_cnt++;
          $display("FAIL bp_release_rinc: cycle %0d rinc=%b required %b", i, s_rinc, i == 7);
        end
      end
    end
    cmp_cnt++;
    if (delivered.size() != 5) begin
      err_cnt++;
      $display("FAIL bp_count: delivered=%0d required 5", delivered.size());
    end
    for (int k = 0; k < 5 && k < delivered.size(); k++) begin
      cmp_cnt++;
      if (delivered[k] !== 32'h11 + 32'(k)) begin
        err_cnt++;
        $display("FAIL bp_order: word %0d=%h required %h", k, delivered[k], 32'h11 + 32'(k));
      end
    end
    cmp_cnt++;
    if (pop_cnt !== 16'd13 || bif.m_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_end: pop_cnt=%0d m_valid=%b required 13 0", pop_cnt, bif.m_valid);
    end
  endtask

  task automatic test_flush();
    fifo_q = '{32'h21, 32'h22, 32'h23};
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    cmp_cnt++;
    if (s_rinc !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_rinc_two: rinc=%b required 0", s_rinc);
    end
    cmp_cnt++;
    if (bif.m_valid !== 1'b0 || pop_cnt !== 16'd15) begin
      err_cnt++;
      $display("FAIL flush_after: m_valid=%b pop_cnt=%0d required 0 15", bif.m_valid, pop_cnt);
    end
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    cmp_cnt++;
    if (s_mv !== 1'b1 || s_md !== 32'h23) begin
      err_cnt++;
      $display("FAIL flush_next_word: m_valid=%b m_data=%h required 1 23", s_mv, s_md);
    end
    drive_cycle(1'b1, 1'b0, 1'b0);
    // flush from ONE while the FIFO still has data: the pop must be blocked
    fifo_q = '{32'h31, 32'h32};
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    cmp_cnt++;
    if (s_rinc !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_rinc_one: rinc=%b required 0", s_rinc);
    end
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    cmp_cnt++;
    if (s_mv !== 1'b1 || s_md !== 32'h32) begin
      err_cnt++;
      $display("FAIL flush_one_next: m_valid=%b m_data=%h required 1 32", s_mv, s_md);
    end
    drive_cycle(1'b1, 1'b0, 1'b0);
    cmp_cnt++;
    if (pop_cnt !== 16'd18) begin
      err_cnt++;
      $display("FAIL flush_cnt: pop_cnt=%0d required 18", pop_cnt);
    end
  endtask

  task automatic test_wrap();
    bif4.m_ready = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      bif4.rempty = (k >= 17);
      bif4.rdata  = 32'(k);
      cmp_cnt++;
      if (pop_cnt4 !== 4'(k % 16)) begin
        err_cnt++;
        $display("FAIL wrap_cnt: cycle %0d pop_cnt=%0d required %0d", k, pop_cnt4, k % 16);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] next_word;
    next_word = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      while (fifo_q.size() < 4) begin
        fifo_q.push_back(next_word);
        next_word++;
      end
      drive_cycle(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive_cycle(1'b1, 1'b0, 1'b1);
    cmp_cnt++;
    if (exp_q.size() != 0 || bif.m_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rand_drain: left=%0d m_valid=%b required 0 0", exp_q.size(), bif.m_valid);
    end
    cmp_cnt++;
    if (pop_cnt !== 16'(total_pushes)) begin
      err_cnt++;
      $display("FAIL rand_cnt: pop_cnt=%0d required %0d", pop_cnt, 16'(total_pushes));
    end
  endtask

  initial begin
    cmp_cnt      = 0;
    err_cnt      = 0;
    total_pushes = 0;
    last_stall   = 1'b0;
    last_md      = '0;
    bif4.rempty  = 1'b1;
    bif4.rdata   = '0;
    bif4.flush   = 1'b0;
    bif4.m_ready = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
